// File: rtl/mrv_bus_pkg.sv
// Shared types and constants for the miniRV data-bus bridge.
// Holds the bridge state encoding, the default timeout, the error read
// value and the helpers that derive the device-select field width.
package mrv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Default number of ACCESS cycles without ack before an access is aborted.
  localparam int DEF_TIMEOUT_CYC = 16;

  // Every bit of the read data returned with an error response.
  localparam logic ERR_RDATA_BIT = 1'b0;

  // Width of the device-select field for a given channel count.
  function automatic int sel_width(input int num_dev);
    return (num_dev > 1) ? $clog2(num_dev) : 1;
  endfunction

  // Width of the address tag above the device-select field.
  function automatic int tag_width(input int addr_w, input int sel_lsb, input int num_dev);
    return addr_w - sel_lsb - sel_width(num_dev);
  endfunction

endpackage

// File: rtl/mrv_bus_decode.sv
// Combinational address decoder for the data-bus bridge.
// Takes the address bits above the device offset, reports whether the tag
// matches BASE_TAG and which device channel the select field names.
module mrv_bus_decode
  import mrv_bus_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                SEL_LSB  = 12,
  parameter int                NUM_DEV  = 4,
  parameter logic [ADDR_W-1:0] BASE_TAG = ADDR_W'('hFFFFF >> sel_width(NUM_DEV))
) (
  input  logic [ADDR_W-SEL_LSB-1:0]       page,
  output logic                            hit,
  output logic [sel_width(NUM_DEV)-1:0]   sel
);

  localparam int SEL_W = sel_width(NUM_DEV);
  localparam int TAG_W = tag_width(ADDR_W, SEL_LSB, NUM_DEV);

  // Select field sits directly above the device offset; the tag is the rest.
  assign sel = page[SEL_W-1:0];
  assign hit = (page[ADDR_W-SEL_LSB-1:SEL_W] == BASE_TAG[TAG_W-1:0]);

endmodule

// File: rtl/mrv_dbus_bridge.sv
// Data-bus bridge between the miniRV core data port and NUM_DEV slaves.
// The core request is decoded, latched and presented as a one-hot dev_req
// until the selected slave acks; the core is stalled meanwhile and gets a
// one-cycle cpu_rvalid pulse with read data and an error flag.
// Optional access timeout: define BUS_TIMEOUT_EN.
// Handshake: the core holds cpu_req until cpu_rvalid; a slave completes an
// access by raising dev_ack[sel] in any cycle while dev_req[sel] is high.
module mrv_dbus_bridge
  import mrv_bus_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_DEV     = 4,
  parameter int                SEL_LSB     = 12,
  parameter logic [ADDR_W-1:0] BASE_TAG    = ADDR_W'('hFFFFF >> sel_width(NUM_DEV)),
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      fpga_clk,
  input  logic                      fpga_rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [DATA_W/8-1:0]       cpu_wstrb,
  output logic                      cpu_stall,
  output logic                      cpu_rvalid,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_err,
  output logic [NUM_DEV-1:0]        dev_req,
  output logic                      dev_we,
  output logic [SEL_LSB-1:0]        dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  output logic [DATA_W/8-1:0]       dev_wstrb,
  input  logic [NUM_DEV-1:0]        dev_ack,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  output bus_state_e                dbg_state
);

  localparam int SEL_W  = sel_width(NUM_DEV);
  localparam int STRB_W = DATA_W / 8;

  // Unsupported parameter sets stop elaboration.
  if ((DATA_W % 8) != 0 || NUM_DEV < 2 || (NUM_DEV & (NUM_DEV - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mrv_dbus_bridge: unsupported parameter set");
  end

  bus_state_e          state_q;
  logic [SEL_W-1:0]    sel_q;
  logic                we_q;
  logic [SEL_LSB-1:0]  addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [NUM_DEV-1:0]  dev_req_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                rvalid_q;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]    tmo_q;
`endif

  mrv_bus_decode #(
    .ADDR_W   (ADDR_W),
    .SEL_LSB  (SEL_LSB),
    .NUM_DEV  (NUM_DEV),
    .BASE_TAG (BASE_TAG)
  ) u_decode (
    .page (cpu_addr[ADDR_W-1:SEL_LSB]),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // Only the latched channel's ack and read data are looked at.
  assign ack_sel   = dev_ack[sel_q];
  assign rdata_sel = dev_rdata[int'(sel_q)*DATA_W +: DATA_W];

  // Stall follows the request while idle and is forced during the access.
  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      ST_IDLE:   cpu_stall = cpu_req;
      ST_ACCESS: cpu_stall = 1'b1;
      default:   cpu_stall = 1'b0;
    endcase
  end

  // Bridge FSM: decode and latch in IDLE, wait for ack in ACCESS, respond in RESP.
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      dev_req_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          if (cpu_req) begin
            if (dec_hit) begin
              sel_q     <= dec_sel;
              we_q      <= cpu_we;
              addr_q    <= cpu_addr[SEL_LSB-1:0];
              wdata_q   <= cpu_wdata;
              wstrb_q   <= cpu_wstrb;
              dev_req_q <= NUM_DEV'(1) << dec_sel;
              state_q   <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
              tmo_q     <= '0;
`endif
            end else begin
              rdata_q  <= {DATA_W{ERR_RDATA_BIT}};
              err_q    <= 1'b1;
              rvalid_q <= 1'b1;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_sel) begin
            dev_req_q <= '0;
            rdata_q   <= we_q ? '0 : rdata_sel;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b1;
            state_q   <= ST_RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
            // This cycle is the TIMEOUT_CYC-th without ack: abandon the slave.
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
              dev_req_q <= '0;
              rdata_q   <= {DATA_W{ERR_RDATA_BIT}};
              err_q     <= 1'b1;
              rvalid_q  <= 1'b1;
              state_q   <= ST_RESP;
            end
          end
`endif
        end
        ST_RESP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          dev_req_q <= '0;
          rvalid_q  <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign dev_req    = dev_req_q;
  assign dev_we     = we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_wstrb  = wstrb_q;
  assign dbg_state  = state_q;

endmodule
